// File: rtl/pc_unit_pkg.sv
// Shared control definitions for the program-counter stage: Psel encodings,
// control-word field positions and the word-size constant.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PSEL_HOLD = 2'b00,
    PSEL_INC  = 2'b01,
    PSEL_REG  = 2'b10,
    PSEL_REL  = 2'b11
  } psel_e;

  localparam int CW_WIDTH    = 29;
  localparam int CW_PSEL_HI  = 28;
  localparam int CW_PSEL_LO  = 27;
  localparam int CW_PCSEL    = 1;

  localparam logic [63:0] WORD_BYTES = 64'd4;

  // True when an address is not aligned to a 4-byte instruction word.
  function automatic logic is_misaligned(input logic [63:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Purely combinational next-PC selector/adder; flags non-sequential updates
// (is_branch) and any real load of the PC (loads).
module pc_next_calc
  import pc_unit_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [1:0]  psel,
  input  logic        pcsel,
  input  logic [63:0] k,
  input  logic [63:0] in_val,
  output logic [63:0] next_pc,
  output logic        is_branch,
  output logic        loads
);

  logic [63:0] off_s;
  logic [63:0] seq_s;

  assign off_s = pcsel ? k : in_val;
  assign seq_s = pc + WORD_BYTES;

  // Select the next PC; the offset shift drops off[63:62] by construction.
  always_comb begin
    next_pc   = pc;
    is_branch = 1'b0;
    loads     = 1'b0;
    case (psel_e'(psel))
      PSEL_HOLD: begin
        next_pc = pc;
      end
      PSEL_INC: begin
        next_pc = seq_s;
        loads   = 1'b1;
      end
      PSEL_REG: begin
        next_pc   = in_val;
        is_branch = 1'b1;
        loads     = 1'b1;
      end
      PSEL_REL: begin
        next_pc   = seq_s + {off_s[61:0], 2'b00};
        is_branch = 1'b1;
        loads     = 1'b1;
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Architectural program counter with sticky misalignment flag and a
// saturating taken-branch counter for debug.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pc_en,
  input  logic [1:0]       Psel,
  input  logic             PCsel,
  input  logic [63:0]      K,
  input  logic [63:0]      in,
  input  logic             clr_status,
  output logic [63:0]      PC,
  output logic [63:0]      PC4,
  output logic             misalign,
  output logic [CNT_W-1:0] branch_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [63:0]      pc_r;
  logic             misalign_r;
  logic [CNT_W-1:0] count_r;

  logic [63:0]      next_pc_s;
  logic             is_branch_s;
  logic             loads_s;

  pc_next_calc u_next (
    .pc        (pc_r),
    .psel      (Psel),
    .pcsel     (PCsel),
    .k         (K),
    .in_val    (in),
    .next_pc   (next_pc_s),
    .is_branch (is_branch_s),
    .loads     (loads_s)
  );

  // PC register: loads on every enabled cycle, never gated on clr_status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= RESET_PC;
    end else if (pc_en) begin
      pc_r <= next_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Debug status: clear has priority over any flag set or count increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      misalign_r <= 1'b0;
      count_r    <= '0;
    end else if (clr_status) begin
      misalign_r <= 1'b0;
      count_r    <= '0;
    end else if (pc_en) begin
      if (loads_s && is_misaligned(next_pc_s)) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end
      if (is_branch_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end else begin
      misalign_r <= misalign_r;
      count_r    <= count_r;
    end
  end

  assign PC           = pc_r;
  assign PC4          = pc_r + WORD_BYTES;
  assign misalign     = misalign_r;
  assign branch_count = count_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// followed by randomized traffic against a behavioural PC model.
module tb_pc_unit;

  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pc_en = 1'b0;
  logic [1:0]    Psel = 2'b00;
  logic          PCsel = 1'b0;
  logic [63:0]   K = 64'd0;
  logic [63:0]   in = 64'd0;
  logic          clr_status = 1'b0;
  logic [63:0]   PC;
  logic [63:0]   PC4;
  logic          misalign;
  logic [CW-1:0] branch_count;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  logic [63:0] m_pc = 64'd0;
  logic        m_mis = 1'b0;
  int          m_cnt = 0;

  pc_unit #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .pc_en(pc_en), .Psel(Psel), .PCsel(PCsel),
    .K(K), .in(in), .clr_status(clr_status), .PC(PC), .PC4(PC4),
    .misalign(misalign), .branch_count(branch_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'd0;
    m_mis = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_apply(input logic en, input logic [1:0] ps, input logic pcs,
                             input logic [63:0] kk, input logic [63:0] ii, input logic clr);
    logic [63:0] nx;
    case (ps)
      2'd0: nx = m_pc;
      2'd1: nx = m_pc + 64'd4;
      2'd2: nx = ii;
      default: nx = m_pc + 64'd4 + (pcs ? kk : ii) * 64'd4;
    endcase
    if (clr) begin
      m_mis = 1'b0;
      m_cnt = 0;
    end else if (en) begin
      if (ps != 2'd0 && (nx % 64'd4) != 64'd0) m_mis = 1'b1;
      if (ps >= 2'd2 && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
    if (en) m_pc = nx;
  endtask

  task automatic step(input logic en, input logic [1:0] ps, input logic pcs,
                      input logic [63:0] kk, input logic [63:0] ii, input logic clr);
    @(negedge clock);
    pc_en = en; Psel = ps; PCsel = pcs; K = kk; in = ii; clr_status = clr;
    @(posedge clock);
    model_apply(en, ps, pcs, kk, ii, clr);
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("pc", PC, m_pc);
      chk("pc4", PC4, m_pc + 64'd4);
      chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
      chk("count", {{(64-CW){1'b0}}, branch_count}, 64'(m_cnt));
    end
  end

  initial begin
    logic [31:0] r;
    logic [63:0] kk;
    logic [63:0] ii;

    // Reset held across a clock pulse.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", PC, 64'h0);
    chk("rst_pc4", PC4, 64'h4);
    chk("rst_mis", {63'd0, misalign}, 64'd0);
    chk("rst_cnt", {{(64-CW){1'b0}}, branch_count}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk_on = 1'b1;

    // Asynchronous reset mid-cycle discards PC=0x40.
    step(1'b1, 2'b10, 1'b0, 64'd0, 64'h40, 1'b0);
    chk("load40", PC, 64'h40);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst", PC, 64'h0);
    pc_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Sequential and hold.
    step(1'b1, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("seq1", PC, 64'd4);
    step(1'b1, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("seq2", PC, 64'd8);
    step(1'b1, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("seq3", PC, 64'd12);
    step(1'b0, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("hold", PC, 64'd12);

    // Backward relative branch through K.
    step(1'b1, 2'b10, 1'b0, 64'd0, 64'h100, 1'b1);
    step(1'b1, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
    chk("rel_k_pc", PC, 64'hFC);
    chk("rel_k_cnt", {{(64-CW){1'b0}}, branch_count}, 64'd1);

    // Misaligned register branch, sticky flag, clear.
    step(1'b1, 2'b10, 1'b0, 64'd0, 64'h2002, 1'b0);
    chk("mis_pc", PC, 64'h2002);
    chk("mis_set", {63'd0, misalign}, 64'd1);
    step(1'b1, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("mis_seq_pc", PC, 64'h2006);
    chk("mis_sticky", {63'd0, misalign}, 64'd1);
    step(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b1);
    chk("clr_mis", {63'd0, misalign}, 64'd0);
    chk("clr_cnt", {{(64-CW){1'b0}}, branch_count}, 64'd0);

    // Wrap at top of address space, then relative offset from in.
    step(1'b1, 2'b10, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step(1'b1, 2'b01, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("wrap_pc", PC, 64'h0);
    chk("wrap_mis", {63'd0, misalign}, 64'd0);
    step(1'b1, 2'b11, 1'b0, 64'hDEAD, 64'd5, 1'b0);
    chk("rel_in_pc", PC, 64'h18);

    // Offset bits [63:62] drop out of the shifted offset.
    step(1'b1, 2'b11, 1'b1, 64'hC000_0000_0000_0001, 64'd0, 1'b0);
    chk("off_trunc", PC, 64'h20);

    // Counter saturation, then clear together with a register branch.
    repeat (CMAX + 3) step(1'b1, 2'b11, 1'b1, 64'd0, 64'd0, 1'b0);
    chk("sat_cnt", {{(64-CW){1'b0}}, branch_count}, 64'(CMAX));
    step(1'b1, 2'b11, 1'b1, 64'd0, 64'd0, 1'b0);
    chk("sat_hold", {{(64-CW){1'b0}}, branch_count}, 64'(CMAX));
    step(1'b1, 2'b10, 1'b0, 64'd0, 64'h500, 1'b1);
    chk("clr_upd_cnt", {{(64-CW){1'b0}}, branch_count}, 64'd0);
    chk("clr_upd_pc", PC, 64'h500);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      kk = (r[0]) ? {{48{r[31]}}, r[31:16]} : {$urandom, $urandom};
      ii = (r[1]) ? {32'd0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      step(r[4:2] != 3'd0, r[6:5], r[7], kk, ii, r[11:8] == 4'd0);
    end

    @(negedge clock);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter register stage directly downstream of the per-opcode control-word decoders (B, BL, CBZ, BR, ALU ops, ...).
- Consumes the Psel and PCsel fields of the 29-bit control word plus the 64-bit K constant and a 64-bit register/ALU operand.
- Updates the architectural PC once per enabled cycle and supplies PC and PC+4 (link value) back to the datapath and instruction memory.
- Keeps a sticky misalignment flag and a taken-branch counter for debug.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of the taken-branch counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- pc_en  input  1  PC update enable; asserted by the sequencer on the final cycle of an instruction.
- Psel  input  2  PC operation: 00 hold, 01 PC+4, 10 PC<-in, 11 PC<-PC+4+offset*4.
- PCsel  input  1  offset source for Psel=11: 1 selects K, 0 selects in.
- K  input  64  sign-extended constant from the decoder.
- in  input  64  register/ALU operand (branch register or CBZ-resolved offset).
- clr_status  input  1  synchronous clear of misalign and branch_count.
- PC  output  64  current program counter (registered).
- PC4  output  64  PC+4, combinational from the PC register.
- misalign  output  1  sticky flag: PC was loaded with a value whose bits[1:0] were nonzero.
- branch_count  output  CNT_W  number of taken non-sequential updates (Psel=10 or 11).

Behaviour:
- Reset (reset_n low, asynchronous): PC=RESET_PC, misalign=0, branch_count=0. PC4 therefore reads RESET_PC+4.
  - Reset deassertion needs no synchronisation inside this block.
  - Reset asserted mid-instruction discards any pending update.
- pc_en=0: PC, misalign and branch_count hold. Psel, PCsel, K and in are ignored.
- pc_en=1, registered at the rising edge:
  - Psel=00: PC holds. Counter unchanged.
  - Psel=01: PC <= PC+4.
  - Psel=10: PC <= in. branch_count increments.
  - Psel=11: PC <= PC + 4 + (off << 2), where off = PCsel ? K : in. branch_count increments.
- Latency: one cycle from pc_en edge to new PC visible; PC4 follows with zero added latency.
- Arithmetic: all adds are 64-bit modulo 2^64.
  - off<<2 discards off[63:62].
  - PC near 2^64-4 with Psel=01 wraps to 0 with no flag.
  - Negative K (two's complement) yields backward branches.
- Misalignment:
  - The next-PC value is checked each time an update is applied.
  - If next[1:0] != 0, misalign is set and stays set until clr_status or reset.
  - The misaligned PC is still loaded; no trapping.
- branch_count saturates at all-ones; no wrap.
- clr_status=1 together with a pc_en update:
  - The clear wins for both misalign and branch_count.
  - The PC update still occurs.
- No internal FSM beyond the registers; sequencing (state/nextState) is owned upstream. pc_unit must never gate on the instruction state itself.

Decomposition:
- Shared control package holds:
  - Psel encodings: PSEL_HOLD=2'b00, PSEL_INC=2'b01, PSEL_REG=2'b10, PSEL_REL=2'b11.
  - Control-word field bit positions, with Psel in [28:27] and PCsel at [1].
  - The 64-bit word-size constant 4.
- One natural sub-module, pc_next_calc: a purely combinational next-PC mux/adder producing next_pc and is_branch, so the decoder bench can reuse it.
- Registers and counters stay in pc_unit.

Test Plan:
- Reset: hold reset_n=0, pulse clock -> PC=0, PC4=4, misalign=0, branch_count=0. Then drop reset_n asynchronously mid-cycle with PC=0x40 -> PC=0 immediately.
- Sequential: pc_en=1, Psel=01 for 3 cycles from 0 -> PC=4, 8, 12. Then pc_en=0 with Psel=01 -> PC stays 12.
- Relative branch via K: PC=0x100, Psel=11, PCsel=1, K=64'hFFFF_FFFF_FFFF_FFFE (-2) -> PC=0x100+4-8=0xFC, branch_count=1.
- Register branch misaligned: Psel=10, in=0x2002 -> PC=0x2002, misalign=1. Next Psel=01 -> PC=0x2006, misalign stays 1. clr_status=1 -> misalign=0, branch_count=0.
- Wrap and offset from in: PC=64'hFFFF_FFFF_FFFF_FFFC, Psel=01 -> PC=0. Then Psel=11, PCsel=0, in=5 -> PC=0x18.
- Simultaneous clear and saturation: branch_count forced to all-ones, Psel=11 -> count stays all-ones. Then clr_status=1 with Psel=10 -> count=0 and PC=in.
